pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage in-order pipeline (F, D, E, M, W).
- Drives the Stall and Flush inputs of every inter-stage pipeline register.
  - Index k = register feeding stage k: 0=PC/F, 1=D, 2=E, 3=M, 4=W.
- Resolves these events with a fixed priority: exception, data-memory wait, multi-cycle MDU operation, branch mispredict, load-use hazard.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- MDU_LAT, 32, total cycles a mult/div occupies E (≥2).
- CNT_W, 6, width of the MDU countdown (must hold MDU_LAT-1).
- PERF_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- exc_i  in  1  exception signalled by instruction in M
- dmem_req_i  in  1  M-stage load/store valid this cycle
- dmem_ready_i  in  1  data memory completes access this cycle
- mdu_start_i  in  1  mult/div entering E, held until acknowledged by state change
- mispredict_i  in  1  branch in E resolved mispredicted
- load_use_i  in  1  D instruction needs load result currently in E
- stall_o  out  5  per-register hold enable
- flush_o  out  5  per-register clear
- mdu_done_o  out  1  one-cycle pulse, MDU result valid in E
- busy_o  out  1  state != RUN
- stall_cnt_o  out  PERF_W  cycles with stall_o != 0, saturating

Behaviour:
- Reset:
  - state=RUN, counter=0.
  - stall_o=0, flush_o=0, mdu_done_o=0, busy_o=0, stall_cnt_o=0.
- stall_o/flush_o are combinational from state + inputs. state, counter and stall_cnt_o are registered.
- stall_o[k] and flush_o[k] are never both high.
- RUN state, first matching rule applies:
  1. exc_i: flush_o=5'b01110 (D,E,M), stall_o=0. Stay RUN. Lower-priority inputs are ignored.
  2. dmem_req_i & !dmem_ready_i: stall_o=5'b01111, flush_o=5'b10000. Next state MEM_WAIT.
  3. mdu_start_i: stall_o=5'b00111, flush_o=5'b01000. Counter loads MDU_LAT-2. Next state MDU_BUSY.
  4. mispredict_i: flush_o=5'b00110 (D,E), stall_o=0.
  5. load_use_i: stall_o=5'b00011, flush_o=5'b00100.
  6. Otherwise stall_o=flush_o=0.
- MEM_WAIT state:
  - While !dmem_ready_i: same outputs as RUN rule 2.
  - On dmem_ready_i: evaluate RUN rules 1, 3, 4, 5, 6 (rule 2 treated as satisfied). Next state follows those rules; RUN unless rule 3 fires.
- MDU_BUSY state:
  - exc_i: abort. Apply RUN rule 1 outputs, clear counter, next RUN, no mdu_done_o.
  - Else if counter != 0: stall_o=5'b00111, flush_o=5'b01000, counter decrements.
  - Counter==0: mdu_done_o=1, stall_o=flush_o=0, next RUN. mdu_start_i is ignored this cycle (the op already in E advances).
  - The MDU op therefore holds E for exactly MDU_LAT cycles, including the start cycle.
  - mispredict_i and load_use_i are ignored while stalled; their sources hold because upstream registers are stalled.
- busy_o = (state != RUN), registered.
- stall_cnt_o increments each cycle stall_o != 0 and saturates at all-ones.
- Asynchronous reset mid-MEM_WAIT or mid-MDU_BUSY returns to RUN immediately. No pulse is emitted.

Optional Feature:
- Macro: PIPE_DELAY_SLOT_EN.
- Defined: MIPS branch delay slot. Mispredict flushes D only (flush_o=5'b00010); the delay-slot instruction in D proceeds to E.
- Undefined: mispredict flushes D and E (5'b00110).
- Affects the RUN and MEM_WAIT-ready paths identically.

Test Plan:
- Reset held 3 cycles, then released, all inputs 0 → stall_o=0, flush_o=0, busy_o=0, stall_cnt_o=0.
- dmem_req_i=1, dmem_ready_i=0 for 4 cycles, then 1 → stall_o=01111 and flush_o=10000 for 4 cycles, busy_o high 4 cycles, release on ready cycle, stall_cnt_o=4.
- MDU_LAT=4, mdu_start_i pulse → stall_o=00111 for 3 cycles, mdu_done_o high in cycle 4, state RUN after.
- Same start with exc_i in the 2nd busy cycle → flush_o=01110 that cycle, no mdu_done_o, busy_o low next cycle.
- mispredict_i and load_use_i together → flush_o=00110, stall_o=0 (00010 with PIPE_DELAY_SLOT_EN).
- Force stall_cnt_o to 2^PERF_W-2, stall 3 cycles → holds at all-ones, no wrap.

Source files
------------

// File: rtl/pipe_hazard_if.sv
// Hazard-controller handshake bundle: pipeline event inputs and stall/flush outputs.
// master = pipeline side, slave = pipe_hazard_ctrl.
interface pipe_hazard_if #(
  parameter int PERF_W = 32
) ();
  logic              exc_i;
  logic              dmem_req_i;
  logic              dmem_ready_i;
  logic              mdu_start_i;
  logic              mispredict_i;
  logic              load_use_i;
  logic [4:0]        stall_o;
  logic [4:0]        flush_o;
  logic              mdu_done_o;
  logic              busy_o;
  logic [PERF_W-1:0] stall_cnt_o;

  modport master (
    output exc_i, dmem_req_i, dmem_ready_i,
    output mdu_start_i, mispredict_i, load_use_i,
    input  stall_o, flush_o, mdu_done_o,
    input  busy_o, stall_cnt_o
  );

  modport slave (
    input  exc_i, dmem_req_i, dmem_ready_i,
    input  mdu_start_i, mispredict_i, load_use_i,
    output stall_o, flush_o, mdu_done_o,
    output busy_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with saturating stall counter.
// Option: PIPE_DELAY_SLOT_EN makes a mispredict flush only D (branch delay slot).
module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 6,
  parameter int PERF_W  = 32
) (
  input logic           clk,
  input logic           reset,
  pipe_hazard_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_BUSY = 2'd2
  } state_t;

  localparam logic [4:0] EXC_FLUSH = 5'b01110;
  localparam logic [4:0] MEM_STALL = 5'b01111;
  localparam logic [4:0] MEM_FLUSH = 5'b10000;
  localparam logic [4:0] MDU_STALL = 5'b00111;
  localparam logic [4:0] MDU_FLUSH = 5'b01000;
  localparam logic [4:0] LU_STALL  = 5'b00011;
  localparam logic [4:0] LU_FLUSH  = 5'b00100;
`ifdef PIPE_DELAY_SLOT_EN
  localparam logic [4:0] MISP_FLUSH = 5'b00010;
`else
  localparam logic [4:0] MISP_FLUSH = 5'b00110;
`endif
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 2);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PERF_W-1:0] perf;
  logic [4:0]        stall, flush;
  logic              done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
      perf  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (|stall && !(&perf))
        perf <= perf + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = '0;
    flush     = '0;
    done      = 1'b0;
    unique case (state)
      RUN, MEM_WAIT: begin
        if (state == MEM_WAIT)
          state_nxt = RUN;
        // memory not done: hold everything up to M, bubble into W
        if ((state == MEM_WAIT && !hz.dmem_ready_i) ||
            (state == RUN && !hz.exc_i &&
             hz.dmem_req_i && !hz.dmem_ready_i)) begin
          stall     = MEM_STALL;
          flush     = MEM_FLUSH;
          state_nxt = MEM_WAIT;
        end else if (hz.exc_i) begin
          flush = EXC_FLUSH;
        end else if (hz.mdu_start_i) begin
          stall     = MDU_STALL;
          flush     = MDU_FLUSH;
          cnt_nxt   = CNT_LOAD;
          state_nxt = MDU_BUSY;
        end else if (hz.mispredict_i) begin
          flush = MISP_FLUSH;
        end else if (hz.load_use_i) begin
          stall = LU_STALL;
          flush = LU_FLUSH;
        end
      end
      MDU_BUSY: begin
        if (hz.exc_i) begin
          flush     = EXC_FLUSH;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end else if (cnt != '0) begin
          stall   = MDU_STALL;
          flush   = MDU_FLUSH;
          cnt_nxt = cnt - 1'b1;
        end else begin
          done      = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign hz.stall_o     = stall;
  assign hz.flush_o     = flush;
  assign hz.mdu_done_o  = done;
  assign hz.busy_o      = (state != RUN);
  assign hz.stall_cnt_o = perf;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (MDU_LAT=4, narrow counter for saturation).
module tb_pipe_hazard_ctrl;
  localparam int PW = 5;

  typedef struct packed {
    logic [4:0]    stall;
    logic [4:0]    flush;
    logic          done;
    logic          busy;
    logic [PW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [PW-1:0] exp_cnt = '0;

`ifdef PIPE_DELAY_SLOT_EN
  localparam logic [4:0] MISP = 5'b00010;
`else
  localparam logic [4:0] MISP = 5'b00110;
`endif

  always #5 clk = ~clk;

  pipe_hazard_if #(.PERF_W(PW)) hz ();

  pipe_hazard_ctrl #(
    .MDU_LAT(4),
    .CNT_W(6),
    .PERF_W(PW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hz(hz)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(logic [5:0] v);
    {hz.exc_i, hz.dmem_req_i, hz.dmem_ready_i,
     hz.mdu_start_i, hz.mispredict_i, hz.load_use_i} = v;
  endtask

  // in = {exc, req, rdy, start, misp, lu}
  task automatic step(string tag, logic [5:0] in,
                      logic [4:0] es, logic [4:0] ef,
                      logic ed, logic eb);
    exp_t e;
    exp_t o;
    @(negedge clk);
    drive(in);
    e = '{stall: es, flush: ef, done: ed, busy: eb, cnt: exp_cnt};
    sb.push_back(e);
    if (es != 5'd0 && exp_cnt != '1)
      exp_cnt = exp_cnt + 1'b1;
    #2;
    o = sb.pop_front();
    chk({tag, ".stall"}, 32'(hz.stall_o), 32'(o.stall));
    chk({tag, ".flush"}, 32'(hz.flush_o), 32'(o.flush));
    chk({tag, ".done"}, 32'(hz.mdu_done_o), 32'(o.done));
    chk({tag, ".busy"}, 32'(hz.busy_o), 32'(o.busy));
    chk({tag, ".cnt"}, 32'(hz.stall_cnt_o), 32'(o.cnt));
  endtask

  initial begin
    drive(6'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step("rst", 6'b000000, 5'b00000, 5'b00000, 0, 0);

    // memory wait 4 cycles then ready
    step("mw0", 6'b010000, 5'b01111, 5'b10000, 0, 0);
    for (int i = 0; i < 3; i++)
      step("mw", 6'b010000, 5'b01111, 5'b10000, 0, 1);
    step("mwr", 6'b011000, 5'b00000, 5'b00000, 0, 1);
    step("mwi", 6'b000000, 5'b00000, 5'b00000, 0, 0);
    chk("cnt4", 32'(hz.stall_cnt_o), 32'd4);

    // MDU op, start held until state change
    step("md0", 6'b000100, 5'b00111, 5'b01000, 0, 0);
    step("md1", 6'b000100, 5'b00111, 5'b01000, 0, 1);
    step("md2", 6'b000100, 5'b00111, 5'b01000, 0, 1);
    step("mdd", 6'b000100, 5'b00000, 5'b00000, 1, 1);
    step("mdi", 6'b000000, 5'b00000, 5'b00000, 0, 0);

    // MDU abort by exception in 2nd busy cycle
    step("ab0", 6'b000100, 5'b00111, 5'b01000, 0, 0);
    step("ab1", 6'b000100, 5'b00111, 5'b01000, 0, 1);
    step("abx", 6'b100100, 5'b00000, 5'b01110, 0, 1);
    step("abi", 6'b000000, 5'b00000, 5'b00000, 0, 0);

    step("mplu", 6'b000011, 5'b00000, MISP, 0, 0);
    step("lu", 6'b000001, 5'b00011, 5'b00100, 0, 0);
    step("exc", 6'b110111, 5'b00000, 5'b01110, 0, 0);

    // ready in MEM_WAIT together with MDU start
    step("mm0", 6'b010000, 5'b01111, 5'b10000, 0, 0);
    step("mm1", 6'b011100, 5'b00111, 5'b01000, 0, 1);
    step("mm2", 6'b000100, 5'b00111, 5'b01000, 0, 1);
    step("mm3", 6'b000100, 5'b00111, 5'b01000, 0, 1);
    step("mmd", 6'b000000, 5'b00000, 5'b00000, 1, 1);

    // ready in MEM_WAIT with exception / mispredict
    step("me0", 6'b010000, 5'b01111, 5'b10000, 0, 0);
    step("mex", 6'b111000, 5'b00000, 5'b01110, 0, 1);
    step("mp0", 6'b010000, 5'b01111, 5'b10000, 0, 0);
    step("mpr", 6'b011010, 5'b00000, MISP, 0, 1);
    step("mpi", 6'b000000, 5'b00000, 5'b00000, 0, 0);

    // saturation of the stall counter
    for (int i = 0; i < 20; i++)
      step("sat", 6'b000001, 5'b00011, 5'b00100, 0, 0);
    step("sati", 6'b000000, 5'b00000, 5'b00000, 0, 0);
    chk("satmax", 32'(hz.stall_cnt_o), 32'((1 << PW) - 1));

    // async reset in the middle of a memory wait
    step("ar0", 6'b010000, 5'b01111, 5'b10000, 0, 0);
    step("ar1", 6'b010000, 5'b01111, 5'b10000, 0, 1);
    #1 reset = 1'b1;
    #1;
    chk("ar.busy", 32'(hz.busy_o), 32'd0);
    chk("ar.cnt", 32'(hz.stall_cnt_o), 32'd0);
    chk("ar.done", 32'(hz.mdu_done_o), 32'd0);
    drive(6'b0);
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = '0;
    step("arr", 6'b000000, 5'b00000, 5'b00000, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
